// File: rtl/shift_reg_tx_if.sv
// Handshake and serial-link bundle between a word source and shift_reg_tx.
interface shift_reg_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_i;
  logic             lsb_first_i;
  logic             valid_i;
  logic             ready_o;
  logic             ser_o;
  logic [1:0]       mode_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output data_i, lsb_first_i, valid_i,
    input  ready_o, ser_o, mode_o, busy_o, done_o
  );

  modport slave (
    input  data_i, lsb_first_i, valid_i,
    output ready_o, ser_o, mode_o, busy_o, done_o
  );
endinterface

// File: rtl/shift_reg_tx.sv
// Parallel-to-serial transmitter driving a remote shift_reg receiver.
// Each bit is held CLKDIV cycles; the receiver mode strobe fires on the last
// cycle of every bit period so the receiver samples a settled bit.
module shift_reg_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CLKDIV = 4
) (
  input  logic         clk,
  input  logic         nrst,
  shift_reg_tx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLKDIV - 1);
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_lsb;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_ser;
  logic [1:0]       r_mode;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_lsb_nxt;
  logic [CNT_W-1:0] w_bit_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_ser_nxt;
  logic [1:0]       w_mode_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [DIV_W-1:0] w_div_inc;
  logic [1:0]       w_code;
  logic [1:0]       w_new_code;

  assign w_div_inc  = r_div_cnt + DIV_W'(1);
  assign w_code     = r_lsb ? MODE_SHR : MODE_SHL;
  assign w_new_code = bus.lsb_first_i ? MODE_SHR : MODE_SHL;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next values of counters, shift word and registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_lsb_nxt   = r_lsb;
    w_bit_nxt   = r_bit_cnt;
    w_div_nxt   = r_div_cnt;
    w_ser_nxt   = 1'b0;
    w_mode_nxt  = MODE_HOLD;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_i) begin
          w_state_nxt = S_SHIFT;
          w_data_nxt  = bus.data_i;
          w_lsb_nxt   = bus.lsb_first_i;
          w_bit_nxt   = '0;
          w_div_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_ser_nxt   = bus.lsb_first_i ? bus.data_i[0] : bus.data_i[WIDTH-1];
          w_mode_nxt  = (CLKDIV == 1) ? w_new_code : MODE_HOLD;
        end
      end
      S_SHIFT: begin
        w_busy_nxt = 1'b1;
        if (r_div_cnt == LAST_DIV) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            // Next bit: the word register is shifted so the live bit sits at one end.
            w_bit_nxt  = r_bit_cnt + CNT_W'(1);
            w_div_nxt  = '0;
            w_data_nxt = r_lsb ? {1'b0, r_data[WIDTH-1:1]} : {r_data[WIDTH-2:0], 1'b0};
            w_ser_nxt  = r_lsb ? r_data[1] : r_data[WIDTH-2];
            w_mode_nxt = (CLKDIV == 1) ? w_code : MODE_HOLD;
          end
        end else begin
          w_div_nxt  = w_div_inc;
          w_ser_nxt  = r_ser;
          w_mode_nxt = (w_div_inc == LAST_DIV) ? w_code : MODE_HOLD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_data    <= '0;
      r_lsb     <= 1'b0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_ser     <= 1'b0;
      r_mode    <= MODE_HOLD;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_data    <= w_data_nxt;
      r_lsb     <= w_lsb_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_div_cnt <= w_div_nxt;
      r_ser     <= w_ser_nxt;
      r_mode    <= w_mode_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.ready_o = (r_state == S_IDLE);
  assign bus.ser_o   = r_ser;
  assign bus.mode_o  = r_mode;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;

endmodule
